// File: rtl/can_fabric_pkg.sv
// Shared types and constants for the CAN bus fabric: bus levels,
// fault-injection modes and injector FSM states.
package can_fabric_pkg;

  localparam logic CAN_DOMINANT  = 1'b0;
  localparam logic CAN_RECESSIVE = 1'b1;

  typedef enum logic [1:0] {
    INJ_NONE = 2'd0,
    INJ_DOM  = 2'd1,
    INJ_REC  = 2'd2,
    INJ_INV  = 2'd3
  } inj_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_OFFSET   = 2'd2,
    ST_ACTIVE   = 2'd3
  } inj_state_e;

  // Corrupted RX level for one node under the given injection mode.
  function automatic logic apply_inj(input inj_mode_e mode, input logic raw);
    case (mode)
      INJ_DOM: return CAN_DOMINANT;
      INJ_REC: return CAN_RECESSIVE;
      INJ_INV: return ~raw;
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/can_bus_idle_mon.sv
// Bus idle detector and start-of-frame monitor. The bus is idle after
// IDLE_BITS*BIT_CYC consecutive recessive cycles; the first dominant
// cycle seen while idle is a start of frame.
module can_bus_idle_mon
  import can_fabric_pkg::*;
#(
  parameter int BIT_CYC   = 50,
  parameter int IDLE_BITS = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_level,
  output logic        bus_idle,
  output logic        sof_pulse,
  output logic [15:0] sof_cnt
);

  localparam int unsigned THRESH = IDLE_BITS * BIT_CYC;
  localparam int CNT_W = $clog2(THRESH + 1);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  logic [CNT_W-1:0] rec_cnt;
  logic             sof_hit;

  assign bus_idle = (rec_cnt == THRESH_C);
  assign sof_hit  = (bus_level == CAN_DOMINANT) && bus_idle;

  // Count consecutive recessive cycles, saturating at the idle threshold;
  // reset starts saturated so the bus is idle straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_cnt <= THRESH_C;
    end else if (bus_level == CAN_DOMINANT) begin
      rec_cnt <= '0;
    end else if (!bus_idle) begin
      rec_cnt <= rec_cnt + 1'b1;
    end
  end

  // Register the SOF pulse and count frames (wraps naturally at 16 bits).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sof_pulse <= 1'b0;
      sof_cnt   <= '0;
    end else begin
      sof_pulse <= sof_hit;
      if (sof_hit) sof_cnt <= sof_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/can_bus_fabric.sv
// N-node wired-AND CAN bus with per-node RX delay, a triggered RX fault
// injector and an idle/SOF monitor.
module can_bus_fabric
  import can_fabric_pkg::*;
#(
  parameter int N_NODE    = 4,
  parameter int MAX_DELAY = 16,
  parameter int DELAY_W   = 4,
  parameter int BIT_CYC   = 50,
  parameter int IDLE_BITS = 11,
  parameter int LEN_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_NODE-1:0]         node_tx,
  output logic [N_NODE-1:0]         node_rx,
  input  logic [N_NODE*DELAY_W-1:0] node_delay,
  input  logic [N_NODE-1:0]         inj_mask,
  input  logic [1:0]                inj_mode,
  input  logic                      inj_on_sof,
  input  logic [LEN_W-1:0]          inj_offset,
  input  logic [LEN_W-1:0]          inj_len,
  input  logic                      inj_start,
  output logic                      inj_busy,
  output logic                      inj_done,
  output logic                      bus_level,
  output logic                      bus_idle,
  output logic                      sof_pulse,
  output logic [15:0]               sof_cnt
);

  localparam int unsigned MAX_TAP = MAX_DELAY - 1;
  localparam int TAP_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  // hist_q[0] is the registered bus level; hist_q[k] is the level k cycles older.
  logic [MAX_DELAY-1:0] hist_q;
  logic [N_NODE-1:0]    raw_rx;

  inj_state_e           state_q;
  logic [N_NODE-1:0]    mask_q;
  inj_mode_e            mode_q;
  logic [LEN_W-1:0]     offset_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     cnt_q;

  function automatic logic [TAP_W-1:0] clamp_tap(input logic [DELAY_W-1:0] d);
    if (32'(d) > MAX_TAP) return TAP_W'(MAX_TAP);
    else                  return TAP_W'(d);
  endfunction

  assign bus_level = hist_q[0];
  assign inj_busy  = (state_q != ST_IDLE);

  // Wired-AND bus core feeding the history line.
  // NOTE: the small history line is reset to recessive so node_rx is clean
  // out of reset; an unreset line would show X until it fills.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '1;
    end else begin
      // NOTE: non-blocking assignments make every stage read the old value,
      // giving a true shift; blocking here would collapse the line.
      hist_q[0] <= &node_tx;
      for (int k = 1; k < MAX_DELAY; k++) hist_q[k] <= hist_q[k-1];
    end
  end

  // Tap each node's RX from the history at its clamped delay.
  always_comb begin
    for (int i = 0; i < N_NODE; i++) begin
      raw_rx[i] = hist_q[clamp_tap(node_delay[i*DELAY_W +: DELAY_W])];
    end
  end

  // Apply the latched corruption to masked nodes only while ACTIVE.
  always_comb begin
    // NOTE: full default before the conditional overrides prevents a latch.
    node_rx = raw_rx;
    if (state_q == ST_ACTIVE) begin
      for (int i = 0; i < N_NODE; i++) begin
        if (mask_q[i]) node_rx[i] = apply_inj(mode_q, raw_rx[i]);
      end
    end
  end

  // Injector FSM: latch the request, optionally wait for SOF, count down
  // the offset, then hold ACTIVE for exactly len cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      mode_q   <= INJ_NONE;
      offset_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      inj_done <= 1'b0;
    end else begin
      inj_done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (inj_start) begin
            mask_q   <= inj_mask;
            mode_q   <= inj_mode_e'(inj_mode);
            offset_q <= inj_offset;
            len_q    <= inj_len;
            cnt_q    <= inj_offset;
            state_q  <= inj_on_sof ? ST_WAIT_SOF : ST_OFFSET;
          end
        end
        ST_WAIT_SOF: begin
          if (sof_pulse) begin
            cnt_q   <= offset_q;
            state_q <= ST_OFFSET;
          end
        end
        ST_OFFSET: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (len_q == '0) begin
            state_q  <= ST_IDLE;
            inj_done <= 1'b1;
          end else begin
            cnt_q   <= len_q - 1'b1;
            state_q <= ST_ACTIVE;
          end
        end
        default: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q  <= ST_IDLE;
            inj_done <= 1'b1;
          end
        end
      endcase
    end
  end

  can_bus_idle_mon #(
    .BIT_CYC  (BIT_CYC),
    .IDLE_BITS(IDLE_BITS)
  ) u_idle_mon (
    .clk      (clk),
    .rst      (rst),
    .bus_level(bus_level),
    .bus_idle (bus_idle),
    .sof_pulse(sof_pulse),
    .sof_cnt  (sof_cnt)
  );

endmodule
